// File: rtl/poly_tone_generator.sv
// NUM_CH-channel square-wave tone generator with a registered saturating mixer.
// Define POLY_TONE_NOISE_EN to add a per-channel 15-bit LFSR noise mode (control bit2).
module poly_tone_generator #(
    parameter int NUM_CH       = 4,
    parameter int PERIOD_W     = 16,
    parameter int SAMPLE_W     = 24,
    parameter int RESET_PERIOD = 14205
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wr_en,
    input  logic [$clog2(NUM_CH)+1:0]  wr_addr,
    input  logic [7:0]                 wr_data,
    output logic signed [SAMPLE_W-1:0] sample,
    output logic [NUM_CH-1:0]          ch_phase
);
    localparam int AW    = $clog2(NUM_CH) + 2;
    localparam int SUM_W = SAMPLE_W + $clog2(NUM_CH) + 1;
    localparam int SHIFT = SAMPLE_W - 16;
    localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'((1 << (SAMPLE_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] MIN_S = ~MAX_S;

    logic [AW-1:0]           wr_ch;
    logic [1:0]              wr_reg;
    logic signed [SUM_W-1:0] contrib [NUM_CH];
    logic signed [SUM_W-1:0] sum;

    assign wr_ch  = wr_addr >> 2;
    assign wr_reg = wr_addr[1:0];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam logic [PERIOD_W-1:0] P_INIT = (c == 0) ? PERIOD_W'(RESET_PERIOD) : '0;

        logic [PERIOD_W-1:0]     per_q;
        logic [PERIOD_W-1:0]     cnt_q;
        logic [7:0]              vol_q;
        logic                    en_q;
        logic                    ph_q;
        logic                    sel;
        logic                    sync;
        logic                    active;
        logic                    reload;
        logic                    next_ph;
        logic signed [SUM_W-1:0] mag;

        // Channel indices at or beyond NUM_CH never match, so those writes drop out here.
        assign sel    = wr_en && (wr_ch == AW'(c));
        assign sync   = sel && (wr_reg == 2'd3) && wr_data[1];
        assign active = en_q && (per_q != '0);
        assign reload = !sync && active && (cnt_q == PERIOD_W'(1));

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                per_q <= P_INIT;
                vol_q <= (c == 0) ? 8'd255 : 8'd0;
                en_q  <= (c == 0);
                cnt_q <= PERIOD_W'(1);
                ph_q  <= 1'b0;
            end else begin
                if (sel) begin
                    case (wr_reg)
                        2'd0:    per_q[7:0]          <= wr_data;
                        2'd1:    per_q[PERIOD_W-1:8] <= wr_data[PERIOD_W-9:0];
                        2'd2:    vol_q               <= wr_data;
                        default: en_q                <= wr_data[0];
                    endcase
                end
                // Divider decisions use the register values from before this edge's write.
                if (sync) begin
                    cnt_q <= per_q;
                    ph_q  <= 1'b0;
                end else if (!active) begin
                    cnt_q <= PERIOD_W'(1);
                end else if (reload) begin
                    cnt_q <= per_q;
                    ph_q  <= next_ph;
                end else begin
                    cnt_q <= cnt_q - PERIOD_W'(1);
                end
            end
        end

`ifdef POLY_TONE_NOISE_EN
        logic        noise_q;
        logic [14:0] lfsr_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                noise_q <= 1'b0;
                lfsr_q  <= 15'h0001;
            end else begin
                if (sel && (wr_reg == 2'd3)) noise_q <= wr_data[2];
                if (sync) begin
                    lfsr_q <= 15'h0001;
                end else if (reload && noise_q) begin
                    lfsr_q <= {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
                end
            end
        end

        assign next_ph = noise_q ? lfsr_q[0] : ~ph_q;
`else
        assign next_ph = ~ph_q;
`endif

        assign mag        = SUM_W'(vol_q) << SHIFT;
        assign contrib[c] = active ? (ph_q ? mag : -mag) : '0;
        assign ch_phase[c] = ph_q;
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum = sum + contrib[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample <= '0;
        end else if (sum > MAX_S) begin
            sample <= MAX_S[SAMPLE_W-1:0];
        end else if (sum < MIN_S) begin
            sample <= MIN_S[SAMPLE_W-1:0];
        end else begin
            sample <= sum[SAMPLE_W-1:0];
        end
    end
endmodule
